// File: rtl/level_bucketizer.sv
// Turns a latched per-window edge count into a display bucket with downward hysteresis,
// a decaying peak-hold and a thermometer LED bar. One threshold is compared per cycle.
module level_bucketizer #(
   parameter  int COUNT_W       = 8,
   parameter  int NUM_BUCKETS   = 12,
   parameter  int FULL_SCALE    = 200,
   parameter  int HYST          = 2,
   parameter  int DECAY_UPDATES = 4,
   localparam int BUCKET_W      = $clog2(NUM_BUCKETS)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [COUNT_W-1:0]     count_in,
   input  logic                   count_valid,
   output logic                   ready,
   output logic                   dropped,
   output logic [BUCKET_W-1:0]    bucket,
   output logic [BUCKET_W-1:0]    peak,
   output logic [NUM_BUCKETS-2:0] led_bar,
   output logic                   overrange,
   output logic                   bucket_valid
);

   localparam int WIDE_W = COUNT_W + 5;
   localparam int DEC_W  = (DECAY_UPDATES > 1) ? $clog2(DECAY_UPDATES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HYST, S_UPDATE} state_t;

   // Threshold k folds to a constant at elaboration; the product is kept wide to avoid overflow.
   function automatic logic [WIDE_W-1:0] thr_const(input int k);
      logic [WIDE_W-1:0] prod;
      prod = WIDE_W'(k) * WIDE_W'(FULL_SCALE);
      return prod / WIDE_W'(NUM_BUCKETS);
   endfunction

   function automatic logic [WIDE_W-1:0] thr_sel(input logic [BUCKET_W-1:0] idx);
      logic [WIDE_W-1:0] r;
      r = '0;
      for (int k = 1; k < NUM_BUCKETS; k++)
         if (idx == BUCKET_W'(k)) r = thr_const(k);
      return r;
   endfunction

   state_t                 state_q, state_d;
   logic [COUNT_W-1:0]     count_q, count_d;
   logic [BUCKET_W-1:0]    k_q, k_d;
   logic [BUCKET_W-1:0]    raw_q, raw_d;
   logic [BUCKET_W-1:0]    new_q, new_d;
   logic [BUCKET_W-1:0]    bucket_q, bucket_d;
   logic [BUCKET_W-1:0]    peak_q, peak_d;
   logic [DEC_W-1:0]       dec_q, dec_d;
   logic [NUM_BUCKETS-2:0] led_q, led_d;
   logic                   ovr_q, ovr_d;
   logic                   bvalid_q, bvalid_d;
   logic                   dropped_q, dropped_d;

   logic [WIDE_W-1:0]      count_wide;
   logic [WIDE_W-1:0]      thr_cur;

   assign count_wide = WIDE_W'(count_q);
   // SCAN walks k; HYST needs the threshold of the current bucket, so one table mux serves both.
   assign thr_cur    = thr_sel((state_q == S_SCAN) ? k_q : bucket_q);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves a value unassigned (no latches).
      state_d   = state_q;
      count_d   = count_q;
      k_d       = k_q;
      raw_d     = raw_q;
      new_d     = new_q;
      bucket_d  = bucket_q;
      peak_d    = peak_q;
      dec_d     = dec_q;
      led_d     = led_q;
      ovr_d     = ovr_q;
      bvalid_d  = 1'b0;
      dropped_d = count_valid && (state_q != S_IDLE);

      unique case (state_q)
         S_IDLE: begin
            if (count_valid) begin
               count_d = count_in;
               k_d     = BUCKET_W'(1);
               raw_d   = '0;
               state_d = S_SCAN;
            end
         end
         S_SCAN: begin
            if (count_wide > thr_cur) raw_d = raw_q + 1'b1;
            if (k_q == BUCKET_W'(NUM_BUCKETS - 1)) state_d = S_HYST;
            else                                   k_d     = k_q + 1'b1;
         end
         S_HYST: begin
            if (raw_q >= bucket_q)                                new_d = raw_q;
            else if (count_wide + WIDE_W'(HYST) <= thr_cur)       new_d = raw_q;
            else                                                  new_d = bucket_q;
            state_d = S_UPDATE;
         end
         S_UPDATE: begin
            bucket_d = new_q;
            if (DECAY_UPDATES == 0) begin
               peak_d = new_q;
               dec_d  = '0;
            end else if (new_q >= peak_q) begin
               peak_d = new_q;
               dec_d  = '0;
            end else if (dec_q == DEC_W'(DECAY_UPDATES - 1)) begin
               peak_d = ((peak_q - 1'b1) > new_q) ? (peak_q - 1'b1) : new_q;
               dec_d  = '0;
            end else begin
               dec_d  = dec_q + 1'b1;
            end
            for (int i = 0; i < NUM_BUCKETS - 1; i++)
               led_d[i] = (BUCKET_W'(i) < bucket_d) ||
                          ((peak_d != '0) && (BUCKET_W'(i) == peak_d - 1'b1));
            ovr_d    = count_wide >= WIDE_W'(FULL_SCALE);
            bvalid_d = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         k_q       <= '0;
         raw_q     <= '0;
         new_q     <= '0;
         bucket_q  <= '0;
         peak_q    <= '0;
         dec_q     <= '0;
         led_q     <= '0;
         ovr_q     <= 1'b0;
         bvalid_q  <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         k_q       <= k_d;
         raw_q     <= raw_d;
         new_q     <= new_d;
         bucket_q  <= bucket_d;
         peak_q    <= peak_d;
         dec_q     <= dec_d;
         led_q     <= led_d;
         ovr_q     <= ovr_d;
         bvalid_q  <= bvalid_d;
         dropped_q <= dropped_d;
      end
   end

   assign ready        = (state_q == S_IDLE);
   assign dropped      = dropped_q;
   assign bucket       = bucket_q;
   assign peak         = peak_q;
   assign led_bar      = led_q;
   assign overrange    = ovr_q;
   assign bucket_valid = bvalid_q;

endmodule
